// File: rtl/ispm_port_arbiter.sv
// Round-robin arbiter sharing instruction-scratchpad BRAM port B among NREQ requesters.
// Optional write protection of the low region is enabled by defining ISPM_ARB_WPROT_EN.
module ispm_port_arbiter #(
   parameter int DATA = 32,
   parameter int ADDR = 10,
   parameter int NREQ = 2
`ifdef ISPM_ARB_WPROT_EN
   ,
   parameter int PROT_TOP = 256
`endif
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ-1:0]    req_wr,
   input  logic [NREQ*ADDR-1:0] req_addr,
   input  logic [NREQ*DATA-1:0] req_wdata,
   output logic [NREQ-1:0]    resp_valid,
   output logic [DATA-1:0]    resp_rdata,
   output logic               resp_err,
`ifdef ISPM_ARB_WPROT_EN
   input  logic               wprot_lock,
`endif
   output logic               b_wr,
   output logic [ADDR-1:0]    b_addr,
   output logic [DATA-1:0]    b_din,
   input  logic [DATA-1:0]    b_dout
);

   localparam int IW = (NREQ > 2) ? 2 : 1;

   logic [IW-1:0]   rr;
   logic [IW-1:0]   gnt_id;
   logic            gnt_found;
   logic            accept;
   logic            g_wr;
   logic [ADDR-1:0] g_addr;
   logic [DATA-1:0] g_wdata;
   logic            blocked;
   logic            s1_v, s2_v;
   logic [IW-1:0]   s1_id, s2_id;

   // First valid requester at or above the rotating pointer wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_found && req_valid[(int'(rr) + k) % NREQ]) begin
            gnt_found = 1'b1;
            gnt_id    = IW'((int'(rr) + k) % NREQ);
         end
      end
   end

   assign accept  = gnt_found & ~reset;
   assign g_wr    = req_wr[gnt_id];
   assign g_addr  = req_addr[int'(gnt_id)*ADDR +: ADDR];
   assign g_wdata = req_wdata[int'(gnt_id)*DATA +: DATA];

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = accept && (IW'(i) == gnt_id);
      end
   end

`ifdef ISPM_ARB_WPROT_EN
   logic s1_err, s2_err;

   // A protected write is demoted to a read so the response returns the old contents.
   assign blocked  = g_wr & wprot_lock & (32'(g_addr) < 32'(PROT_TOP));
   assign resp_err = s2_v & s2_err & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_err <= 1'b0;
         s2_err <= 1'b0;
      end else begin
         s1_err <= accept & blocked;
         s2_err <= s1_err;
      end
   end
`else
   assign blocked  = 1'b0;
   assign resp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         rr     <= '0;
         s1_v   <= 1'b0;
         s1_id  <= '0;
         s2_v   <= 1'b0;
         s2_id  <= '0;
         b_wr   <= 1'b0;
         b_addr <= '0;
         b_din  <= '0;
      end else begin
         s2_v  <= s1_v;
         s2_id <= s1_id;
         if (accept) begin
            rr     <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IW'(1);
            s1_v   <= 1'b1;
            s1_id  <= gnt_id;
            b_wr   <= g_wr & ~blocked;
            b_addr <= g_addr;
            b_din  <= g_wdata;
         end else begin
            s1_v <= 1'b0;
            b_wr <= 1'b0;
         end
      end
   end

   // Responses in flight during a reset cycle are suppressed immediately.
   always_comb begin
      resp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         resp_valid[i] = s2_v && !reset && (IW'(i) == s2_id);
      end
   end

   assign resp_rdata = b_dout;

endmodule

// File: tb/tb_ispm_port_arbiter.sv
// Directed self-checking bench for ispm_port_arbiter with three requesters and a write-first BRAM model.
// Exercises the write-protect path when ISPM_ARB_WPROT_EN is defined.
module tb_ispm_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [2:0]  req_wr;
   logic [29:0] req_addr;
   logic [95:0] req_wdata;
   logic [2:0]  resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        b_wr;
   logic [9:0]  b_addr;
   logic [31:0] b_din;
   logic [31:0] b_dout;
`ifdef ISPM_ARB_WPROT_EN
   logic        wprot_lock;
`endif

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [0:1023];

   ispm_port_arbiter #(
      .DATA(32),
      .ADDR(10),
      .NREQ(3)
`ifdef ISPM_ARB_WPROT_EN
      ,
      .PROT_TOP(256)
`endif
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_wr(req_wr),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err),
`ifdef ISPM_ARB_WPROT_EN
      .wprot_lock(wprot_lock),
`endif
      .b_wr(b_wr),
      .b_addr(b_addr),
      .b_din(b_din),
      .b_dout(b_dout)
   );

   always #5 clk = ~clk;

   // Write-first BRAM port B: a write returns its own data on the next cycle.
   always @(posedge clk) begin
      if (b_wr) begin
         mem[b_addr] <= b_din;
         b_dout      <= b_din;
      end else begin
         b_dout <= mem[b_addr];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setField(input int id, input logic [9:0] a, input logic [31:0] d);
      req_addr[id*10 +: 10]  = a;
      req_wdata[id*32 +: 32] = d;
   endtask

   task automatic applyStimulus(input logic [2:0] v, input logic [2:0] w);
      req_valid = v;
      req_wr    = w;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[10'h005] = 32'hDEADBEEF;
      mem[10'h010] = 32'h01010101;
      mem[10'h020] = 32'hC0DE0000;
      mem[10'h021] = 32'hC0DE0001;
      mem[10'h022] = 32'hC0DE0002;
      b_dout    = '0;
      reset     = 1'b1;
      req_addr  = '0;
      req_wdata = '0;
`ifdef ISPM_ARB_WPROT_EN
      wprot_lock = 1'b0;
`endif
      applyStimulus(3'b111, 3'b000);
      tick();
      tick();
      checkOutput("ready_in_reset", 64'(req_ready), 64'h0);
      applyStimulus(3'b000, 3'b000);
      checkOutput("rst_b_wr", 64'(b_wr), 64'h0);
      checkOutput("rst_b_addr", 64'(b_addr), 64'h0);
      checkOutput("rst_b_din", 64'(b_din), 64'h0);
      checkOutput("rst_resp_valid", 64'(resp_valid), 64'h0);
      checkOutput("rst_resp_err", 64'(resp_err), 64'h0);
      reset = 1'b0;

      // Single read by requester 0
      setField(0, 10'h005, 32'h0);
      applyStimulus(3'b001, 3'b000);
      checkOutput("rd_ready", 64'(req_ready), 64'h1);
      tick();
      applyStimulus(3'b000, 3'b000);
      checkOutput("rd_b_addr", 64'(b_addr), 64'h005);
      checkOutput("rd_b_wr", 64'(b_wr), 64'h0);
      checkOutput("rd_resp_early", 64'(resp_valid), 64'h0);
      tick();
      checkOutput("rd_resp_valid", 64'(resp_valid), 64'h1);
      checkOutput("rd_resp_data", 64'(resp_rdata), 64'hDEADBEEF);

      // Write then read-after-write by requester 1 (pointer now 1)
      setField(1, 10'h3FF, 32'h12345678);
      applyStimulus(3'b010, 3'b010);
      checkOutput("wr_ready", 64'(req_ready), 64'h2);
      tick();
      applyStimulus(3'b010, 3'b000);
      checkOutput("raw_ready", 64'(req_ready), 64'h2);
      checkOutput("wr_b_wr", 64'(b_wr), 64'h1);
      checkOutput("wr_b_addr", 64'(b_addr), 64'h3FF);
      checkOutput("wr_b_din", 64'(b_din), 64'h12345678);
      tick();
      applyStimulus(3'b000, 3'b000);
      checkOutput("wr_resp_valid", 64'(resp_valid), 64'h2);
      checkOutput("wr_resp_data", 64'(resp_rdata), 64'h12345678);
      checkOutput("raw_b_wr", 64'(b_wr), 64'h0);
      tick();
      checkOutput("raw_resp_valid", 64'(resp_valid), 64'h2);
      checkOutput("raw_resp_data", 64'(resp_rdata), 64'h12345678);
      tick();

      // Fairness from reset: all three valid for six cycles
      reset = 1'b1;
      tick();
      reset = 1'b0;
      setField(0, 10'h020, 32'h0);
      setField(1, 10'h021, 32'h0);
      setField(2, 10'h022, 32'h0);
      for (int c = 0; c < 8; c++) begin
         applyStimulus((c < 6) ? 3'b111 : 3'b000, 3'b000);
         checkOutput($sformatf("fair_ready_%0d", c), 64'(req_ready),
                     (c < 6) ? 64'(1 << (c % 3)) : 64'h0);
         checkOutput($sformatf("fair_resp_%0d", c), 64'(resp_valid),
                     (c >= 2) ? 64'(1 << ((c - 2) % 3)) : 64'h0);
         if (c >= 2)
            checkOutput($sformatf("fair_data_%0d", c), 64'(resp_rdata),
                        64'(32'hC0DE0000 + 32'((c - 2) % 3)));
         tick();
      end

      // Reset while two reads are in flight
      setField(0, 10'h005, 32'h0);
      applyStimulus(3'b001, 3'b000);
      checkOutput("mid_ready_t0", 64'(req_ready), 64'h1);
      tick();
      setField(1, 10'h021, 32'h0);
      applyStimulus(3'b010, 3'b000);
      checkOutput("mid_ready_t1", 64'(req_ready), 64'h2);
      tick();
      reset = 1'b1;
      applyStimulus(3'b000, 3'b000);
      checkOutput("mid_resp_t2", 64'(resp_valid), 64'h0);
      tick();
      reset = 1'b0;
      applyStimulus(3'b111, 3'b000);
      checkOutput("mid_resp_t3", 64'(resp_valid), 64'h0);
      checkOutput("mid_rr_zero", 64'(req_ready), 64'h1);
      tick();
      applyStimulus(3'b000, 3'b000);
      tick();
      tick();
      tick();

      // Idle for ten cycles, pointer must remain at 1
      for (int c = 0; c < 10; c++) begin
         checkOutput($sformatf("idle_ready_%0d", c), 64'(req_ready), 64'h0);
         checkOutput($sformatf("idle_b_wr_%0d", c), 64'(b_wr), 64'h0);
         checkOutput($sformatf("idle_resp_%0d", c), 64'(resp_valid), 64'h0);
         tick();
      end
      applyStimulus(3'b111, 3'b000);
      checkOutput("idle_rr_hold", 64'(req_ready), 64'h2);
      tick();

      // Lone requester 0 holding valid is accepted every cycle
      for (int c = 0; c < 3; c++) begin
         applyStimulus(3'b001, 3'b000);
         checkOutput($sformatf("solo_ready_%0d", c), 64'(req_ready), 64'h1);
         tick();
      end
      applyStimulus(3'b000, 3'b000);
      tick();
      tick();
      tick();

`ifdef ISPM_ARB_WPROT_EN
      // Protected write is demoted to a read and flagged
      wprot_lock = 1'b1;
      setField(0, 10'h010, 32'hAAAA5555);
      applyStimulus(3'b001, 3'b001);
      checkOutput("wp_ready", 64'(req_ready), 64'h1);
      tick();
      applyStimulus(3'b000, 3'b000);
      checkOutput("wp_b_wr", 64'(b_wr), 64'h0);
      tick();
      checkOutput("wp_resp_err", 64'(resp_err), 64'h1);
      checkOutput("wp_resp_data", 64'(resp_rdata), 64'h01010101);
      checkOutput("wp_mem", 64'(mem[10'h010]), 64'h01010101);
      setField(0, 10'h100, 32'hAAAA5555);
      applyStimulus(3'b001, 3'b001);
      tick();
      applyStimulus(3'b000, 3'b000);
      checkOutput("wp_hi_b_wr", 64'(b_wr), 64'h1);
      tick();
      checkOutput("wp_hi_resp_err", 64'(resp_err), 64'h0);
      checkOutput("wp_hi_resp_data", 64'(resp_rdata), 64'hAAAA5555);
      checkOutput("wp_hi_mem", 64'(mem[10'h100]), 64'hAAAA5555);
      wprot_lock = 1'b0;
`else
      // Without protection a low-address write goes through unflagged
      setField(0, 10'h010, 32'hAAAA5555);
      applyStimulus(3'b001, 3'b001);
      checkOutput("lo_ready", 64'(req_ready), 64'h1);
      tick();
      applyStimulus(3'b000, 3'b000);
      checkOutput("lo_b_wr", 64'(b_wr), 64'h1);
      tick();
      checkOutput("lo_resp_err", 64'(resp_err), 64'h0);
      checkOutput("lo_resp_data", 64'(resp_rdata), 64'hAAAA5555);
      checkOutput("lo_mem", 64'(mem[10'h010]), 64'hAAAA5555);
`endif
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
